// File: rtl/memwb_pipe_reg.sv
// memwb_pipe_reg: parametrised MEM/WB pipeline register with valid/stall/flush,
// load byte/half/word extraction, 3-way writeback select and x0-qualified write.
// Ports: clk, reset (sync, active-low), stall_i, flush_i, valid_in,
//   read_data_in, result_alu_in, pc_plus4_in, rd_in, regwrite_in, wb_sel_in,
//   funct3_in, addr_lo_in -> valid_out, rd_out, regwrite_out, wb_data_out,
//   fwd_en_out; retire_cnt_out only when MEMWB_RETIRE_CNT_EN is defined.
// Optional feature macro: MEMWB_RETIRE_CNT_EN (64-bit retired-instruction count).
module memwb_pipe_reg #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int OFF_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   read_data_in,
    input  logic [XLEN-1:0]   result_alu_in,
    input  logic [XLEN-1:0]   pc_plus4_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              regwrite_in,
    input  logic [1:0]        wb_sel_in,
    input  logic [2:0]        funct3_in,
    input  logic [OFF_W-1:0]  addr_lo_in,
`ifdef MEMWB_RETIRE_CNT_EN
    output logic [63:0]       retire_cnt_out,
`endif
    output logic              valid_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              regwrite_out,
    output logic [XLEN-1:0]   wb_data_out,
    output logic              fwd_en_out
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              regwrite_q, regwrite_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;

    always_comb begin
        valid_d    = valid_q;
        rdata_d    = rdata_q;
        alu_d      = alu_q;
        pc4_d      = pc4_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        wb_sel_d   = wb_sel_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        if (flush_i || !stall_i) begin
            // A flush still captures the data fields; only valid is killed.
            valid_d    = valid_in && !flush_i;
            rdata_d    = read_data_in;
            alu_d      = result_alu_in;
            pc4_d      = pc_plus4_in;
            rd_d       = rd_in;
            regwrite_d = regwrite_in;
            wb_sel_d   = wb_sel_in;
            funct3_d   = funct3_in;
            off_d      = addr_lo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            wb_sel_q   <= 2'b00;
            funct3_q   <= 3'b000;
            off_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            wb_sel_q   <= wb_sel_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
        end
    end

    // Force natural alignment; doubleword (and 111) always reads from offset 0.
    logic [OFF_W-1:0] eff_off;
    logic [OFF_W+2:0] shamt;
    logic [XLEN-1:0]  shifted;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_w;
    logic [XLEN-1:0]  load_ext;

    always_comb begin
        eff_off = off_q;
        unique case (funct3_q[1:0])
            2'b00: eff_off = off_q;
            2'b01: eff_off[0] = 1'b0;
            2'b10: eff_off[1:0] = 2'b00;
            2'b11: eff_off = '0;
        endcase
    end

    assign shamt   = {eff_off, 3'b000};
    assign shifted = rdata_q >> shamt;
    assign ld_b    = shifted[7:0];
    assign ld_h    = shifted[15:0];
    assign ld_w    = shifted[31:0];

    // With XLEN=32 the word offset is always 0, so 011/110/111 collapse to LW.
    always_comb begin
        load_ext = rdata_q;
        unique case (funct3_q)
            3'b000: load_ext = XLEN'($signed(ld_b));
            3'b001: load_ext = XLEN'($signed(ld_h));
            3'b010: load_ext = XLEN'($signed(ld_w));
            3'b011: load_ext = rdata_q;
            3'b100: load_ext = XLEN'(ld_b);
            3'b101: load_ext = XLEN'(ld_h);
            3'b110: load_ext = XLEN'(ld_w);
            3'b111: load_ext = rdata_q;
        endcase
    end

    always_comb begin
        wb_data_out = '0;
        unique case (wb_sel_q)
            2'b00: wb_data_out = alu_q;
            2'b01: wb_data_out = load_ext;
            2'b10: wb_data_out = pc4_q;
            2'b11: wb_data_out = '0;
        endcase
    end

    assign valid_out    = valid_q;
    assign rd_out       = rd_q;
    assign regwrite_out = valid_q && regwrite_q && (rd_q != '0);
    assign fwd_en_out   = regwrite_out;

`ifdef MEMWB_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    // An instruction leaves WB on any non-stalled edge while valid.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stall_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// tb_memwb_pipe_reg: directed bench for memwb_pipe_reg (XLEN=64 default).
// Checks reset, loads, writeback select, x0 suppression, stall, flush, counter.
module tb_memwb_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        valid_in;
    logic [63:0] read_data_in;
    logic [63:0] result_alu_in;
    logic [63:0] pc_plus4_in;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  funct3_in;
    logic [2:0]  addr_lo_in;
    logic        valid_out;
    logic [4:0]  rd_out;
    logic        regwrite_out;
    logic [63:0] wb_data_out;
    logic        fwd_en_out;
    logic [63:0] retire_cnt_out;

    int passed = 0;
    int total  = 0;

    memwb_pipe_reg #(.XLEN(64), .REG_AW(5), .OFF_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .valid_in      (valid_in),
        .read_data_in  (read_data_in),
        .result_alu_in (result_alu_in),
        .pc_plus4_in   (pc_plus4_in),
        .rd_in         (rd_in),
        .regwrite_in   (regwrite_in),
        .wb_sel_in     (wb_sel_in),
        .funct3_in     (funct3_in),
        .addr_lo_in    (addr_lo_in),
`ifdef MEMWB_RETIRE_CNT_EN
        .retire_cnt_out(retire_cnt_out),
`endif
        .valid_out     (valid_out),
        .rd_out        (rd_out),
        .regwrite_out  (regwrite_out),
        .wb_data_out   (wb_data_out),
        .fwd_en_out    (fwd_en_out)
    );

`ifndef MEMWB_RETIRE_CNT_EN
    assign retire_cnt_out = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [4:0] rd,
                            input logic rw, input logic [63:0] wb);
        chk({tag, ".valid"}, 64'(valid_out), 64'(v));
        chk({tag, ".rd"}, 64'(rd_out), 64'(rd));
        chk({tag, ".regwrite"}, 64'(regwrite_out), 64'(rw));
        chk({tag, ".fwd"}, 64'(fwd_en_out), 64'(rw));
        chk({tag, ".wb"}, wb_data_out, wb);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3,
                      input logic [2:0] off, input logic [63:0] exp);
        funct3_in  = f3;
        addr_lo_in = off;
        step();
        chk(tag, wb_data_out, exp);
    endtask

    initial begin
        reset         = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        valid_in      = 1'b1;
        read_data_in  = 64'hDEAD_BEEF_0000_1111;
        result_alu_in = 64'h5555;
        pc_plus4_in   = 64'h44;
        rd_in         = 5'd3;
        regwrite_in   = 1'b1;
        wb_sel_in     = 2'b00;
        funct3_in     = 3'b000;
        addr_lo_in    = 3'd0;
        step();
        step();
        chk_outs("reset", 1'b0, 5'd0, 1'b0, 64'h0);
        chk("reset.cnt", retire_cnt_out, 64'h0);

        reset         = 1'b1;
        rd_in         = 5'd5;
        result_alu_in = 64'h1234;
        step();
        chk_outs("first", 1'b1, 5'd5, 1'b1, 64'h1234);

        read_data_in = 64'h8877_6655_4433_2211;
        wb_sel_in    = 2'b01;
        rd_in        = 5'd3;
        ld("lb7",  3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88);
        ld("lbu7", 3'b100, 3'd7, 64'h0000_0000_0000_0088);
        ld("lb0",  3'b000, 3'd0, 64'h0000_0000_0000_0011);
        ld("lh3",  3'b001, 3'd3, 64'h0000_0000_0000_4433);
        ld("lh7",  3'b001, 3'd7, 64'hFFFF_FFFF_FFFF_8877);
        ld("lhu7", 3'b101, 3'd7, 64'h0000_0000_0000_8877);
        ld("lw4",  3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655);
        ld("lw3",  3'b010, 3'd3, 64'h0000_0000_4433_2211);
        ld("lwu4", 3'b110, 3'd4, 64'h0000_0000_8877_6655);
        ld("ld5",  3'b011, 3'd5, 64'h8877_6655_4433_2211);
        ld("f111", 3'b111, 3'd6, 64'h8877_6655_4433_2211);

        pc_plus4_in = 64'h1000_0004;
        wb_sel_in   = 2'b10;
        step();
        chk("sel_pc4", wb_data_out, 64'h1000_0004);
        wb_sel_in = 2'b11;
        step();
        chk("sel_zero", wb_data_out, 64'h0);

        wb_sel_in = 2'b00;
        rd_in     = 5'd0;
        step();
        chk_outs("x0", 1'b1, 5'd0, 1'b0, 64'h1234);

        rd_in       = 5'd8;
        valid_in    = 1'b0;
        step();
        chk("inv.regwrite", 64'(regwrite_out), 64'h0);
        valid_in    = 1'b1;
        regwrite_in = 1'b0;
        step();
        chk("norw.regwrite", 64'(regwrite_out), 64'h0);
        regwrite_in = 1'b1;

        rd_in         = 5'd7;
        result_alu_in = 64'hAA;
        step();
        chk_outs("pre_stall", 1'b1, 5'd7, 1'b1, 64'hAA);
        stall_i       = 1'b1;
        rd_in         = 5'd9;
        result_alu_in = 64'hBB;
        valid_in      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs("stall", 1'b1, 5'd7, 1'b1, 64'hAA);
        end
        stall_i  = 1'b0;
        valid_in = 1'b1;
        step();
        chk_outs("release", 1'b1, 5'd9, 1'b1, 64'hBB);

        stall_i = 1'b1;
        reset   = 1'b0;
        step();
        chk_outs("rst_stall", 1'b0, 5'd0, 1'b0, 64'h0);
        reset   = 1'b1;
        stall_i = 1'b0;

        rd_in = 5'd4;
        step();
        chk_outs("pre_flush", 1'b1, 5'd4, 1'b1, 64'hBB);
        flush_i = 1'b1;
        stall_i = 1'b1;
        step();
        chk("flush.valid", 64'(valid_out), 64'h0);
        chk("flush.regwrite", 64'(regwrite_out), 64'h0);
        chk("flush.fwd", 64'(fwd_en_out), 64'h0);
        flush_i = 1'b0;
        stall_i = 1'b0;
        step();
        chk("post_flush.valid", 64'(valid_out), 64'h1);

`ifdef MEMWB_RETIRE_CNT_EN
        reset = 1'b0;
        step();
        chk("cnt.reset", retire_cnt_out, 64'h0);
        reset    = 1'b1;
        valid_in = 1'b1;
        step();
        step();
        stall_i = 1'b1;
        step();
        step();
        chk("cnt.stall", retire_cnt_out, 64'd1);
        stall_i = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        chk("cnt.flush", retire_cnt_out, 64'd3);
        flush_i = 1'b0;
        step();
        chk("cnt.bubble", retire_cnt_out, 64'd3);
        valid_in = 1'b0;
        step();
        step();
        chk("cnt.final", retire_cnt_out, 64'd4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
